// File: rtl/priority_arbiter.sv
// Four-requester arbiter, fixed or round-robin, with registered one-hot grant and 1-cycle latency.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rr_mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       val
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] last_id;
  logic       timeout;
  logic       arb;
  logic [3:0] cand;
  logic       win_vld;
  logic [1:0] win_id;
  logic [1:0] idx;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  // Only time out when someone else is waiting; a lone owner just restarts its count.
  assign timeout = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD - 1)) && |(req & ~gnt);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    cand    = timeout ? (req & ~gnt) : req;
    arb     = (state == IDLE) ? |req : (!req[gnt_id] || timeout);
    win_vld = |cand;
    win_id  = 2'd0;
    idx     = 2'd0;
    if (!rr_mode) begin
      for (int i = 0; i < 4; i++)
        if (cand[i]) win_id = 2'(i);
    end else begin
      // Walk from farthest to nearest so the first index after last_id wins.
      for (int k = 4; k >= 1; k--) begin
        idx = last_id + 2'(k);
        if (cand[idx]) win_id = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_id  <= 2'd0;
      val     <= 1'b0;
      last_id <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else if (arb) begin
      if (win_vld) begin
        state   <= GRANT;
        gnt     <= 4'b0001 << win_id;
        gnt_id  <= win_id;
        val     <= 1'b1;
        last_id <= win_id;
      end else begin
        state  <= IDLE;
        gnt    <= 4'b0000;
        gnt_id <= 2'd0;
        val    <= 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end
`ifdef ARB_TIMEOUT_EN
    else if (state == GRANT) begin
      hold_cnt <= (hold_cnt == 8'(MAX_HOLD - 1)) ? 8'd0 : hold_cnt + 8'd1;
    end
`endif
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter; outputs sampled 1ns after each rising edge.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rr_mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       val;

  int tests = 0;
  int fails = 0;

  priority_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_id(gnt_id), .val(val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {gnt, gnt_id, val} for comparison.
  function automatic logic [7:0] outs();
    return {1'b0, gnt, gnt_id, val};
  endfunction

  function automatic logic [7:0] exp_of(input int id);
    logic [3:0] g;
    g = 4'b0001 << id;
    return {1'b0, g, 2'(id), 1'b1};
  endfunction

  localparam logic [7:0] IDLE_O = 8'h00;

  initial begin
    rst_n = 1'b0; req = 4'b0000; rr_mode = 1'b0;
    #3;
    chk("reset_async", outs(), IDLE_O);
    req = 4'b1111;
    tick();
    chk("reset_held", outs(), IDLE_O);
    rst_n = 1'b1;
    req = 4'b0000;
    #1;
    chk("after_release", outs(), IDLE_O);

    // Fixed priority, no-bubble handover
    req = 4'b0101; tick(); chk("fixed_0101", outs(), exp_of(2));
    req = 4'b0001; tick(); chk("fixed_drop2", outs(), exp_of(0));

`ifndef ARB_TIMEOUT_EN
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_1001", outs(), exp_of(0));
    end
    rr_mode = 1'b1;
    tick(); chk("hold_rrchg", outs(), exp_of(0));
    rr_mode = 1'b0;
`endif

    req = 4'b0000; tick(); chk("to_idle", outs(), IDLE_O);
    req = 4'b0110; tick(); chk("fixed_0110", outs(), exp_of(2));
    req = 4'b0011; tick(); chk("fixed_0011", outs(), exp_of(1));
    req = 4'b0000; tick(); chk("to_idle2", outs(), IDLE_O);

    // Reset mid-grant of requester 2
    req = 4'b0100; tick(); chk("pre_reset", outs(), exp_of(2));
    #2 rst_n = 1'b0;
    #1 chk("reset_midgrant", outs(), IDLE_O);
    tick();
    rst_n = 1'b1;
    chk("reset_release", outs(), IDLE_O);

    // Round-robin from fresh reset: order 0,1,2,3,0
    rr_mode = 1'b1;
    req = 4'b1111; tick(); chk("rr_first0", outs(), exp_of(0));
    req = 4'b1110; tick(); chk("rr_1", outs(), exp_of(1));
    req = 4'b1101; tick(); chk("rr_2", outs(), exp_of(2));
    req = 4'b1011; tick(); chk("rr_3", outs(), exp_of(3));
    req = 4'b0111; tick(); chk("rr_wrap0", outs(), exp_of(0));

    // Release to idle from owner 3
    rr_mode = 1'b0;
    req = 4'b1000; tick(); chk("own3", outs(), exp_of(3));
    req = 4'b0000; tick(); chk("rel_idle", outs(), IDLE_O);
    for (int i = 0; i < 10; i++) begin
      tick(); chk("idle_stay", outs(), IDLE_O);
    end

`ifdef ARB_TIMEOUT_EN
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("timeout_alt", outs(), ((i / 4) % 2 == 0) ? exp_of(1) : exp_of(0));
    end
    req = 4'b0000; tick();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("lone_owner", outs(), exp_of(0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per owner when the timeout feature is compiled in (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: one request line per requester; index 3 is highest fixed priority.
REQ-005 The block SHALL have port rr_mode, input, 1 bit: 0 = fixed priority, 1 = round-robin; sampled only at arbitration points.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered one-hot grant; all zero when no grant.
REQ-007 The block SHALL have port gnt_id, output, 2 bits: registered binary index of the current owner; 0 when no grant.
REQ-008 The block SHALL have port val, output, 1 bit: registered; 1 exactly when gnt is nonzero.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 An arbitration point SHALL occur in IDLE on any cycle with req nonzero, and in GRANT on any cycle where req[gnt_id] is 0 or a timeout fires.
REQ-011 At an arbitration point the winner SHALL be chosen from req sampled that cycle; gnt, gnt_id and val SHALL reflect the winner after the next rising edge (1-cycle latency).
REQ-012 Fixed mode SHALL select the highest-indexed asserted request.
REQ-013 Round-robin mode SHALL search indices last_id+1, last_id+2, ... modulo 4 (wrap 3->0) and select the first asserted request; last_id is the most recent owner.
REQ-014 IDLE -> GRANT on any arbitration with a winner; IDLE -> IDLE when req is 0.
REQ-015 In GRANT, while req[gnt_id] stays 1 and no timeout fires, the grant SHALL hold unchanged regardless of other requests or rr_mode changes.
REQ-016 When the owner drops req and other requests exist, GRANT -> GRANT with the new winner on the next edge (no idle bubble); when req is 0, GRANT -> IDLE and gnt, gnt_id, val return to 0.
REQ-017 A released owner re-asserting req in the same cycle it drops SHALL NOT exist; a requester that drops req for one cycle and re-asserts SHALL be re-arbitrated normally.
REQ-018 last_id SHALL update to the winner at every grant.
REQ-019 gnt SHALL never have more than one bit set, and gnt[gnt_id] SHALL equal val in every cycle.

Reset
REQ-020 Assertion of rst_n low SHALL immediately, without a clock, force state IDLE, gnt=4'b0000, gnt_id=2'd0, val=0, last_id=2'd3, and hold counter 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant immediately; after release, the first round-robin search SHALL start at index 0.
REQ-022 Outputs SHALL remain at reset values until the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN SHALL, when defined, compile in an 8-bit hold counter that clears on every new grant and increments each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 and any other requester is asserted, a timeout SHALL fire: re-arbitration excludes the current owner (both modes) and the new winner is granted next edge.
REQ-025 With ARB_TIMEOUT_EN defined and no other requester, the owner SHALL keep the grant and the counter SHALL clear and continue counting.
REQ-026 Without ARB_TIMEOUT_EN, no counter SHALL exist and an owner SHALL hold the grant indefinitely while requesting.

Verification
REQ-027 Reset check: rst_n=0 mid-grant of requester 2 -> gnt=0000, gnt_id=0, val=0 within the same cycle, no clock edge needed.
REQ-028 Fixed priority: rr_mode=0, req=0101 from IDLE -> next edge gnt=0100, gnt_id=2; drop req[2] (req=0001) -> next edge gnt=0001, gnt_id=0, no bubble.
REQ-029 Round-robin: rr_mode=1, req=1111 held, each owner drops req for one cycle after its grant -> grant order 0,1,2,3,0.
REQ-030 Hold: rr_mode=0, requester 0 granted, then req=1001 -> gnt stays 0001 while req[0]=1 (without ARB_TIMEOUT_EN).
REQ-031 Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 constant, rr_mode=0 -> gnt 0010 for 4 cycles, then 0001 for 4 cycles, alternating.
REQ-032 Release to idle: single owner 3, req goes 1000->0000 -> next edge val=0, gnt=0000; req=0000 for 10 cycles -> val stays 0.
